// File: rtl/boot_loader.sv
// UART-fed program loader: assembles little-endian words from a byte stream and
// writes them to consecutive data-memory words while holding the core in reset.
`timescale 1ns/1ps
module boot_loader #(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned MAX_WORDS      = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter bit          BOOT_HOLD      = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        cpu_reset,
   output logic        Ext_MemWrite,
   output logic [31:0] Ext_DataAdr,
   output logic [31:0] Ext_WriteData,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] word_count,
   output logic [2:0]  dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN    = 3'd1,
      S_DATA   = 3'd2,
      S_WRITE  = 3'd3,
      S_FINISH = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   localparam logic [31:0] BASE_AL  = {BASE_ADDR[31:2], 2'b00};
   localparam logic [31:0] MAX_W    = 32'(MAX_WORDS);
   localparam int          TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       shift_q, shift_d;
   logic [31:0]       len_q, len_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [15:0]       wc_q, wc_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              loaded_q, loaded_d;
   logic              mw_q, done_q, err_q, busy_q, cpu_rst_q;

   // rx_valid is a one-cycle strobe with no back-pressure: a byte is consumed in
   // the very cycle rx_valid is high if the FSM is in LEN, DATA or WRITE, else dropped.
   logic        in_load, byte_take, last_byte, tmo_hit;
   logic [31:0] shift_nx;

   always_comb begin
      in_load   = (state_q == S_LEN) || (state_q == S_DATA);
      byte_take = rx_valid && (in_load || (state_q == S_WRITE));
      last_byte = byte_take && (idx_q == 2'd3);
      tmo_hit   = in_load && !rx_valid && (tmo_q == TMO_LAST);
      shift_nx  = {rx_data, shift_q[31:8]};
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_LEN;
         S_LEN: begin
            if (tmo_hit) state_d = S_ERR;
            else if (last_byte) begin
               if (shift_nx == 32'd0)   state_d = S_FINISH;
               else if (shift_nx > MAX_W) state_d = S_ERR;
               else                     state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tmo_hit)        state_d = S_ERR;
            else if (last_byte) state_d = S_WRITE;
         end
         S_WRITE:  state_d = ((32'(wc_q) + 32'd1) == len_q) ? S_FINISH : S_DATA;
         S_FINISH: state_d = S_IDLE;
         S_ERR:    if (start) state_d = S_LEN;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      idx_d    = idx_q;
      shift_d  = shift_q;
      len_d    = len_q;
      tmo_d    = tmo_q;
      wc_d     = wc_q;
      adr_d    = adr_q;
      wdata_d  = wdata_q;
      loaded_d = loaded_q | (state_q == S_FINISH);
      if ((state_d == S_LEN) && (state_q != S_LEN)) begin
         idx_d = 2'd0;
         wc_d  = 16'd0;
         tmo_d = '0;
      end else if (byte_take) begin
         // The byte index wraps after each word, so a byte seen in WRITE lands as byte 0.
         shift_d = shift_nx;
         idx_d   = idx_q + 2'd1;
         tmo_d   = '0;
      end else if (in_load) begin
         tmo_d = tmo_q + 1'b1;
      end
      if ((state_q == S_LEN) && last_byte) len_d = shift_nx;
      if ((state_q == S_DATA) && last_byte) begin
         wdata_d = shift_nx;
         adr_d   = BASE_AL + (32'(wc_q) << 2);
      end
      if (state_q == S_WRITE) wc_d = wc_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q     <= 2'd0;
         shift_q   <= 32'd0;
         len_q     <= 32'd0;
         tmo_q     <= '0;
         wc_q      <= 16'd0;
         adr_q     <= BASE_AL;
         wdata_q   <= 32'd0;
         loaded_q  <= 1'b0;
         mw_q      <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         cpu_rst_q <= BOOT_HOLD;
      end else begin
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         len_q     <= len_d;
         tmo_q     <= tmo_d;
         wc_q      <= wc_d;
         adr_q     <= adr_d;
         wdata_q   <= wdata_d;
         loaded_q  <= loaded_d;
         mw_q      <= (state_d == S_WRITE);
         done_q    <= (state_d == S_FINISH);
         err_q     <= (state_d == S_ERR);
         busy_q    <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
         cpu_rst_q <= (state_d != S_IDLE) || (BOOT_HOLD && !loaded_d);
      end
   end

   assign cpu_reset     = cpu_rst_q;
   assign Ext_MemWrite  = mw_q;
   assign Ext_DataAdr   = adr_q;
   assign Ext_WriteData = wdata_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = err_q;
   assign word_count    = wc_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a BASE_ADDR 0 / BOOT_HOLD 1 instance plus a
// wrap-around BASE_ADDR / BOOT_HOLD 0 instance fed the same stimulus.
`timescale 1ns/1ps
module tb_boot_loader;
   localparam int MAXW = 4;
   localparam int TMO  = 40;

   logic        clk = 1'b0;
   logic        reset = 1'b1, start = 1'b0, rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        cpu_reset, Ext_MemWrite, busy, done, error;
   logic [31:0] Ext_DataAdr, Ext_WriteData;
   logic [15:0] word_count;
   logic [2:0]  dbg_state;
   logic        cpu_reset2, mw2, busy2, done2, error2;
   logic [31:0] adr2, wdata2;
   logic [15:0] wc2;
   logic [2:0]  dbg_state2;

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] wr_q[$];
   logic [63:0] wr2_q[$];
   logic [63:0] exp_q[$];

   boot_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO), .BOOT_HOLD(1'b1)) u_dut (
      .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
      .cpu_reset(cpu_reset), .Ext_MemWrite(Ext_MemWrite), .Ext_DataAdr(Ext_DataAdr),
      .Ext_WriteData(Ext_WriteData), .busy(busy), .done(done), .error(error),
      .word_count(word_count), .dbg_state_o(dbg_state));

   boot_loader #(.BASE_ADDR(32'hFFFF_FFFE), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO), .BOOT_HOLD(1'b0)) u_dut2 (
      .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
      .cpu_reset(cpu_reset2), .Ext_MemWrite(mw2), .Ext_DataAdr(adr2),
      .Ext_WriteData(wdata2), .busy(busy2), .done(done2), .error(error2),
      .word_count(wc2), .dbg_state_o(dbg_state2));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (Ext_MemWrite === 1'b1) wr_q.push_back({Ext_DataAdr, Ext_WriteData});
      if (mw2 === 1'b1)          wr2_q.push_back({adr2, wdata2});
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_word32(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset got %0b exp 1", cpu_reset); end
      n_checks++; if (Ext_MemWrite !== 1'b0) begin n_fail++; $display("FAIL rst_memwrite got %0b exp 0", Ext_MemWrite); end
      n_checks++; if ({done, error, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b exp 000", {done, error, busy}); end
      n_checks++; if (Ext_DataAdr !== 32'h0) begin n_fail++; $display("FAIL rst_adr got %h exp 0", Ext_DataAdr); end
      n_checks++; if (Ext_WriteData !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h exp 0", Ext_WriteData); end
      n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL rst_wc got %0d exp 0", word_count); end
      n_checks++; if (cpu_reset2 !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_reset_nohold got %0b exp 0", cpu_reset2); end
      n_checks++; if (adr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_adr_aligned got %h exp fffffffc", adr2); end
      reset = 1'b0;
      repeat (3) tick();
      n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_boot_hold got %0b exp 1", cpu_reset); end
      n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
   endtask

   task automatic test_basic();
      wr_q.delete();
      wr2_q.delete();
      // start and a stray byte in the same IDLE cycle: the byte must be dropped
      start = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
      tick();
      start = 1'b0; rx_valid = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %0b exp 1", busy); end
      n_checks++; if (cpu_reset2 !== 1'b1) begin n_fail++; $display("FAIL basic_cpu_reset_nohold got %0b exp 1", cpu_reset2); end
      send_word32(32'd2);
      send_word32(32'h1234_5678);
      n_checks++; if ({Ext_MemWrite, Ext_DataAdr, Ext_WriteData} !== {1'b1, 32'h0, 32'h1234_5678})
         begin n_fail++; $display("FAIL basic_w0 got %b/%h/%h exp 1/00000000/12345678", Ext_MemWrite, Ext_DataAdr, Ext_WriteData); end
      send_word32(32'hDEAD_BEEF);
      n_checks++; if ({Ext_MemWrite, Ext_DataAdr, Ext_WriteData} !== {1'b1, 32'h4, 32'hDEAD_BEEF})
         begin n_fail++; $display("FAIL basic_w1 got %b/%h/%h exp 1/00000004/deadbeef", Ext_MemWrite, Ext_DataAdr, Ext_WriteData); end
      tick();
      n_checks++; if ({done, Ext_MemWrite, cpu_reset} !== 3'b101) begin n_fail++; $display("FAIL basic_done got done/mw/cpu %b exp 101", {done, Ext_MemWrite, cpu_reset}); end
      n_checks++; if (word_count !== 16'd2) begin n_fail++; $display("FAIL basic_wc got %0d exp 2", word_count); end
      tick();
      n_checks++; if ({done, cpu_reset, busy} !== 3'b000) begin n_fail++; $display("FAIL basic_release got done/cpu/busy %b exp 000", {done, cpu_reset, busy}); end
      tick();
      n_checks++; if (wr_q.size() != 2) begin n_fail++; $display("FAIL basic_nwrites got %0d exp 2", wr_q.size()); end
      else begin
         n_checks++; if (wr_q[0] !== {32'h0, 32'h1234_5678}) begin n_fail++; $display("FAIL basic_log0 got %h", wr_q[0]); end
         n_checks++; if (wr_q[1] !== {32'h4, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL basic_log1 got %h", wr_q[1]); end
      end
      n_checks++; if (wr2_q.size() != 2) begin n_fail++; $display("FAIL wrap_nwrites got %0d exp 2", wr2_q.size()); end
      else begin
         n_checks++; if (wr2_q[0] !== {32'hFFFF_FFFC, 32'h1234_5678}) begin n_fail++; $display("FAIL wrap_log0 got %h exp fffffffc12345678", wr2_q[0]); end
         n_checks++; if (wr2_q[1] !== {32'h0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL wrap_log1 got %h exp 00000000deadbeef", wr2_q[1]); end
      end
   endtask

   task automatic test_len_zero();
      wr_q.delete();
      pulse_start();
      send_word32(32'd0);
      n_checks++; if ({done, busy, cpu_reset} !== 3'b101) begin n_fail++; $display("FAIL zero_done got done/busy/cpu %b exp 101", {done, busy, cpu_reset}); end
      tick();
      n_checks++; if ({done, cpu_reset, error} !== 3'b000) begin n_fail++; $display("FAIL zero_release got done/cpu/err %b exp 000", {done, cpu_reset, error}); end
      n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL zero_wc got %0d exp 0", word_count); end
      tick();
      n_checks++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL zero_nwrites got %0d exp 0", wr_q.size()); end
   endtask

   task automatic test_len_limits();
      wr_q.delete();
      exp_q.delete();
      pulse_start();
      send_word32(32'(MAXW + 1));
      n_checks++; if ({error, cpu_reset, busy} !== 3'b110) begin n_fail++; $display("FAIL over_err got err/cpu/busy %b exp 110", {error, cpu_reset, busy}); end
      repeat (3) tick();
      n_checks++; if ({error, cpu_reset} !== 2'b11) begin n_fail++; $display("FAIL over_sticky got err/cpu %b exp 11", {error, cpu_reset}); end
      pulse_start();
      n_checks++; if ({error, busy} !== 2'b01) begin n_fail++; $display("FAIL over_clear got err/busy %b exp 01", {error, busy}); end
      send_word32(32'(MAXW));
      n_checks++; if ({error, busy} !== 2'b01) begin n_fail++; $display("FAIL max_accept got err/busy %b exp 01", {error, busy}); end
      for (int i = 0; i < MAXW; i++) begin
         send_word32(32'hA000_0000 + 32'(i));
         exp_q.push_back({32'(4 * i), 32'hA000_0000 + 32'(i)});
      end
      tick();
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL max_done got %0b exp 1", done); end
      n_checks++; if (word_count !== 16'(MAXW)) begin n_fail++; $display("FAIL max_wc got %0d exp %0d", word_count, MAXW); end
      repeat (2) tick();
      n_checks++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL max_nwrites got %0d exp %0d", wr_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++; if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL max_log%0d got %h exp %h", i, wr_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_timeout();
      int waited;
      wr_q.delete();
      pulse_start();
      send_word32(32'd3);
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (TMO - 5) tick();
      waited = TMO - 5;
      n_checks++; if ({error, busy} !== 2'b01) begin n_fail++; $display("FAIL tmo_early got err/busy %b exp 01", {error, busy}); end
      for (int j = 0; j < 20 && error !== 1'b1; j++) begin
         tick();
         waited++;
      end
      n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %0b exp 1 after %0d idle clocks", error, waited); end
      n_checks++; if (waited < TMO - 2 || waited > TMO + 2) begin n_fail++; $display("FAIL tmo_window got %0d idle clocks exp about %0d", waited, TMO); end
      n_checks++; if ({cpu_reset, Ext_MemWrite} !== 2'b10) begin n_fail++; $display("FAIL tmo_hold got cpu/mw %b exp 10", {cpu_reset, Ext_MemWrite}); end
      tick();
      n_checks++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL tmo_nwrites got %0d exp 0", wr_q.size()); end
   endtask

   task automatic test_reset_mid();
      wr_q.delete();
      pulse_start();
      send_word32(32'd3);
      send_word32(32'h0102_0304);
      tick();
      send_byte(8'h55);
      reset = 1'b1;
      tick();
      n_checks++; if ({cpu_reset, Ext_MemWrite, busy, done, error} !== 5'b10000) begin n_fail++; $display("FAIL mid_flags got %b exp 10000", {cpu_reset, Ext_MemWrite, busy, done, error}); end
      n_checks++; if ({Ext_DataAdr, Ext_WriteData} !== 64'h0) begin n_fail++; $display("FAIL mid_ext got %h/%h exp 0/0", Ext_DataAdr, Ext_WriteData); end
      n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL mid_wc got %0d exp 0", word_count); end
      n_checks++; if (adr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL mid_adr2 got %h exp fffffffc", adr2); end
      reset = 1'b0;
      repeat (3) tick();
      n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL mid_loaded_cleared got %0b exp 1", cpu_reset); end
      n_checks++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL mid_nwrites got %0d exp 1", wr_q.size()); end
      wr_q.delete();
      pulse_start();
      send_word32(32'd1);
      send_word32(32'h0BAD_F00D);
      n_checks++; if ({Ext_MemWrite, Ext_DataAdr, Ext_WriteData} !== {1'b1, 32'h0, 32'h0BAD_F00D})
         begin n_fail++; $display("FAIL mid_fresh got %b/%h/%h exp 1/00000000/0badf00d", Ext_MemWrite, Ext_DataAdr, Ext_WriteData); end
      repeat (2) tick();
      n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL mid_release got %0b exp 0", cpu_reset); end
      tick();
      n_checks++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL mid_fresh_nwrites got %0d exp 1", wr_q.size()); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  bq[$];
      logic [31:0] w;
      wr_q.delete();
      exp_q.delete();
      for (int i = 0; i < 4; i++) bq.push_back(8'(32'd3 >> (8 * i)));
      for (int k = 0; k < 3; k++) begin
         w = 32'h4433_2211 + 32'(k) * 32'h4444_4444;
         for (int i = 0; i < 4; i++) bq.push_back(w[8*i +: 8]);
         exp_q.push_back({32'(4 * k), w});
      end
      pulse_start();
      for (int i = 0; i < bq.size(); i++) begin
         rx_valid = 1'b1;
         rx_data  = bq[i];
         start    = (i == 9) || (i == 12);
         tick();
      end
      rx_valid = 1'b0;
      start    = 1'b0;
      n_checks++; if ({Ext_MemWrite, Ext_DataAdr, Ext_WriteData} !== {1'b1, 32'h8, 32'hCCBB_AA99})
         begin n_fail++; $display("FAIL b2b_last got %b/%h/%h exp 1/00000008/ccbbaa99", Ext_MemWrite, Ext_DataAdr, Ext_WriteData); end
      tick();
      n_checks++; if ({done, word_count} !== {1'b1, 16'd3}) begin n_fail++; $display("FAIL b2b_done got %0b/%0d exp 1/3", done, word_count); end
      tick();
      n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL b2b_release got %0b exp 0", cpu_reset); end
      tick();
      n_checks++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_nwrites got %0d exp %0d", wr_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++; if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_log%0d got %h exp %h", i, wr_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_zero();
      test_len_limits();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
# boot_loader

Program loader that sits directly upstream of the RV32I core's external memory-write port. It turns a byte stream from a UART receiver into 32-bit little-endian words and writes them into data memory at consecutive word addresses. While loading it holds the core in reset, which is the only condition under which the core accepts external writes. It releases the core once the image is complete.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first loaded word.
- MAX_WORDS, 1024: largest accepted word count.
- TIMEOUT_CYCLES, 1_000_000: maximum idle clocks between bytes during a load.
- BOOT_HOLD, 1: if 1, cpu_reset stays high out of reset until the first successful load; if 0, cpu_reset drops in IDLE.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high block reset.
- start  in  1  single-cycle load request.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- rx_data  in  8  received byte.
- cpu_reset  out  1  drives the core's reset; high while loading.
- Ext_MemWrite  out  1  one-cycle data-memory write strobe.
- Ext_DataAdr  out  32  word-aligned write byte address.
- Ext_WriteData  out  32  assembled word.
- busy  out  1  high in LEN, DATA, WRITE.
- done  out  1  one-cycle pulse when the load completes.
- error  out  1  sticky load-failure flag.
- word_count  out  16  words written in the current or last load.

## Operation
- States: IDLE, LEN, DATA, WRITE, FINISH, ERR.
- IDLE:
  - start -> LEN; clear byte index, word_count and error.
  - rx_valid bytes are ignored in IDLE.
- LEN:
  - Collect 4 bytes, least significant first, into the length register N.
  - On the 4th byte:
    - N == 0 -> FINISH.
    - N > MAX_WORDS -> ERR.
    - otherwise -> DATA.
- DATA:
  - Collect 4 bytes, least significant first.
  - The 4th byte latches Ext_WriteData and Ext_DataAdr = BASE_ADDR + 4*word_count, then -> WRITE.
- WRITE:
  - Ext_MemWrite = 1 for exactly this cycle.
  - word_count increments.
  - word_count+1 == N -> FINISH; else -> DATA.
  - An rx_valid arriving in WRITE is captured as byte 0 of the next word. The byte register continues across the state change, so no byte is lost.
- FINISH:
  - done = 1 for one cycle.
  - Set the internal loaded flag.
  - -> IDLE.
- ERR:
  - error = 1; no writes.
  - Stays in ERR until start (-> LEN, error cleared).
- Timeout:
  - The inter-byte counter resets on every accepted byte and on entry to LEN.
  - In LEN or DATA, if the counter reaches TIMEOUT_CYCLES -> ERR.
  - Words already written are not rolled back.
- start while busy is ignored.
- Address arithmetic is modulo 2^32; BASE_ADDR[1:0] is forced to 0.
- cpu_reset:
  - High in LEN, DATA, WRITE, FINISH and ERR.
  - In IDLE it equals BOOT_HOLD & ~loaded.
- Ext_* outputs are meaningful only while cpu_reset is high.

## Timing
- Reset values:
  - State IDLE, loaded 0.
  - cpu_reset = BOOT_HOLD.
  - Ext_MemWrite, done, error, busy = 0.
  - Ext_DataAdr = BASE_ADDR, Ext_WriteData = 0, word_count = 0.
- All outputs are registered.
- Ext_MemWrite asserts in the cycle after the clock edge that accepts a word's 4th byte.
- Ext_DataAdr and Ext_WriteData are stable in that cycle.
- done pulses one cycle after the last WRITE cycle. cpu_reset falls one cycle after that, on the IDLE entry. The core sees reset deasserted only after the last write has completed.
- Minimum byte spacing is 1 clock: back-to-back rx_valid is supported.
- Reset asserted mid-load:
  - Return to the reset values next edge; no partial write.
  - cpu_reset = BOOT_HOLD.
  - loaded is cleared.
- start and rx_valid in the same cycle in IDLE: the start is taken; the byte is ignored.

## Test plan
- Length 2, then bytes 78 56 34 12 EF BE AD DE, BASE_ADDR 0:
  - Exactly two Ext_MemWrite pulses: (0x0, 0x12345678) then (0x4, 0xDEADBEEF).
  - done one cycle after the second pulse; cpu_reset falls one cycle later; word_count = 2.
- Length 0: no writes; done pulses; cpu_reset falls; error = 0.
- Length MAX_WORDS+1 -> error = 1, no writes, cpu_reset stays high; a later start clears error.
- Stall bytes for TIMEOUT_CYCLES after 2 of a word's 4 bytes -> ERR, no write of the partial word, cpu_reset = 1.
- Block reset asserted after 1 of 3 words written -> outputs return to reset values the next cycle; a fresh load of 1 word writes address BASE_ADDR.
- Continuous back-to-back rx_valid across a WRITE cycle: all bytes land in the correct words; start pulsed mid-load is ignored.
